// File: rtl/hazard_if.sv
// Hazard controller bus: pipeline register addresses and status in, stall/flush/forward controls out.
// The master side is the pipeline; the slave side is hazard_ctrl.
interface hazard_if #(
   parameter int REG_AW    = 5,
   parameter int CNT_WIDTH = 32
);
   logic [REG_AW-1:0]    Rs1D;
   logic [REG_AW-1:0]    Rs2D;
   logic [REG_AW-1:0]    Rs1E;
   logic [REG_AW-1:0]    Rs2E;
   logic [REG_AW-1:0]    RdE;
   logic [REG_AW-1:0]    RdM;
   logic [REG_AW-1:0]    RdW;
   logic                 ResultSrcE0;
   logic                 RegWriteM;
   logic                 RegWriteW;
   logic                 PCSrcE;
   logic                 MemReqM;
   logic                 MemReadyM;
   logic                 PerfClr;
   logic                 StallF;
   logic                 StallD;
   logic                 StallE;
   logic                 StallM;
   logic                 FlushD;
   logic                 FlushE;
   logic                 FlushW;
   logic [1:0]           ForwardAE;
   logic [1:0]           ForwardBE;
   logic                 MemTimeout;
   logic [CNT_WIDTH-1:0] StallCount;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM, PerfClr,
      input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
      input  ForwardAE, ForwardBE, MemTimeout, StallCount
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM, PerfClr,
      output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
      output ForwardAE, ForwardBE, MemTimeout, StallCount
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: forwarding, load-use stall, branch flush,
// data-memory wait freeze with timeout, and a saturating stall-cycle counter.
module hazard_ctrl #(
   parameter int REG_AW    = 5,
   parameter int TIMEOUT   = 256,
   parameter int CNT_WIDTH = 32
) (
   input  logic    clk,
   input  logic    rst_n,
   hazard_if.slave hz
);
   localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WCW-1:0]    WAIT_LAST = WCW'(TIMEOUT - 1);
   localparam logic [REG_AW-1:0] REG_X0    = {REG_AW{1'b0}};
   localparam logic [0:0]        MEM_IDLE  = 1'b0;
   localparam logic [0:0]        MEM_WAIT  = 1'b1;

   logic [0:0]           state_q, state_d;
   logic [WCW-1:0]       waitcnt_q, waitcnt_d;
   logic                 timeout_q, timeout_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;

   logic       mem_stall_s;
   logic       lw_stall_s;
   logic [3:0] stall_s;
   logic [2:0] flush_s;
   logic [1:0] fwd_a_s, fwd_b_s;

   // x0 is hardwired zero, so a write to it is never a forwarding source.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] rs,
      input logic              wr_m,
      input logic [REG_AW-1:0] rd_m,
      input logic              wr_w,
      input logic [REG_AW-1:0] rd_w
   );
      logic [1:0] sel;
      if (wr_m && (rd_m != REG_X0) && (rd_m == rs)) begin
         sel = 2'b10;
      end else if (wr_w && (rd_w != REG_X0) && (rd_w == rs)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Memory-wait FSM; a request dropped mid-wait is treated as completion.
   always_comb begin
      state_d     = state_q;
      waitcnt_d   = waitcnt_q;
      timeout_d   = timeout_q;
      mem_stall_s = 1'b0;
      case (state_q)
         MEM_IDLE: begin
            if (hz.MemReqM && !hz.MemReadyM) begin
               mem_stall_s = 1'b1;
               state_d     = MEM_WAIT;
               waitcnt_d   = WCW'(1);
            end else begin
               state_d = MEM_IDLE;
            end
         end
         MEM_WAIT: begin
            if (!hz.MemReqM || hz.MemReadyM) begin
               state_d   = MEM_IDLE;
               waitcnt_d = {WCW{1'b0}};
            end else if (waitcnt_q == WAIT_LAST) begin
               state_d   = MEM_IDLE;
               waitcnt_d = {WCW{1'b0}};
               timeout_d = 1'b1;
            end else begin
               mem_stall_s = 1'b1;
               waitcnt_d   = waitcnt_q + WCW'(1);
            end
         end
         default: begin
            state_d   = MEM_IDLE;
            waitcnt_d = {WCW{1'b0}};
         end
      endcase
   end

   // Load-use detection against the instruction currently in D.
   always_comb begin
      lw_stall_s = 1'b0;
      if (hz.ResultSrcE0 && (hz.RdE != REG_X0) &&
          ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D))) begin
         lw_stall_s = 1'b1;
      end else begin
         lw_stall_s = 1'b0;
      end
   end

   // Stall/flush priority; while in reset, bubbles are pushed into the un-reset pipe registers.
   always_comb begin
      stall_s = 4'b0000;
      flush_s = 3'b000;
      fwd_a_s = 2'b00;
      fwd_b_s = 2'b00;
      if (!rst_n) begin
         flush_s = 3'b111;
      end else begin
         fwd_a_s = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
         fwd_b_s = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
         if (mem_stall_s) begin
            stall_s = 4'b1111;
            flush_s = 3'b001;
         end else if (hz.PCSrcE) begin
            flush_s = 3'b110;
         end else if (lw_stall_s) begin
            stall_s = 4'b1100;
            flush_s = 3'b010;
         end else begin
            stall_s = 4'b0000;
            flush_s = 3'b000;
         end
      end
   end

   // Stall-cycle counter: clear wins over increment, saturates at all-ones.
   always_comb begin
      count_d = count_q;
      if (hz.PerfClr) begin
         count_d = {CNT_WIDTH{1'b0}};
      end else if (stall_s[3] && (count_q != {CNT_WIDTH{1'b1}})) begin
         count_d = count_q + CNT_WIDTH'(1);
      end else begin
         count_d = count_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= MEM_IDLE;
         waitcnt_q <= {WCW{1'b0}};
         timeout_q <= 1'b0;
         count_q   <= {CNT_WIDTH{1'b0}};
      end else begin
         state_q   <= state_d;
         waitcnt_q <= waitcnt_d;
         timeout_q <= timeout_d;
         count_q   <= count_d;
      end
   end

   assign hz.StallF     = stall_s[3];
   assign hz.StallD     = stall_s[2];
   assign hz.StallE     = stall_s[1];
   assign hz.StallM     = stall_s[0];
   assign hz.FlushD     = flush_s[2];
   assign hz.FlushE     = flush_s[1];
   assign hz.FlushW     = flush_s[0];
   assign hz.ForwardAE  = fwd_a_s;
   assign hz.ForwardBE  = fwd_b_s;
   assign hz.MemTimeout = timeout_q;
   assign hz.StallCount = count_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios followed by random traffic,
// each cycle's expected response produced by a behavioural model and checked by a monitor.
module tb_hazard_ctrl;
   localparam int TOUT  = 4;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_if #(.REG_AW(5), .CNT_WIDTH(CW)) hz ();

   hazard_ctrl #(.REG_AW(5), .TIMEOUT(TOUT), .CNT_WIDTH(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz.slave)
   );

   typedef struct {
      logic       rst_n;
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic       re0, rwm, rww, pcsrc, memreq, memrdy, perfclr;
   } stim_t;

   typedef struct {
      logic [3:0] stall;
      logic [2:0] flush;
      logic [1:0] fa, fb;
      logic       to;
      int         cnt;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad   = 0;

   // Reference model state: waiting or not, cycles stalled so far in this wait.
   bit m_wait = 1'b0;
   int m_n    = 0;
   bit m_to   = 1'b0;
   int m_cnt  = 0;

   function automatic stim_t idle();
      stim_t s;
      s = '{rst_n: 1'b1, rs1d: 5'd0, rs2d: 5'd0, rs1e: 5'd0, rs2e: 5'd0, rde: 5'd0, rdm: 5'd0,
            rdw: 5'd0, re0: 1'b0, rwm: 1'b0, rww: 1'b0, pcsrc: 1'b0, memreq: 1'b0,
            memrdy: 1'b0, perfclr: 1'b0};
      return s;
   endfunction

   function automatic logic [1:0] fwd(input stim_t s, input logic [4:0] rs);
      if (s.rwm && s.rdm != 5'd0 && s.rdm == rs) return 2'b10;
      if (s.rww && s.rdw != 5'd0 && s.rdw == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model(input stim_t s, output exp_t e);
      bit ms, lw;
      e.to  = m_to;
      e.cnt = m_cnt;
      if (!s.rst_n) begin
         e = '{stall: 4'b0000, flush: 3'b111, fa: 2'b00, fb: 2'b00, to: 1'b0, cnt: 0};
         m_wait = 1'b0; m_n = 0; m_to = 1'b0; m_cnt = 0;
         return;
      end
      e.fa = fwd(s, s.rs1e);
      e.fb = fwd(s, s.rs2e);
      ms = 1'b0;
      if (!m_wait) begin
         if (s.memreq && !s.memrdy) begin ms = 1'b1; m_wait = 1'b1; m_n = 1; end
      end else if (!s.memreq || s.memrdy) begin
         m_wait = 1'b0;
      end else if (m_n == TOUT - 1) begin
         m_wait = 1'b0; m_to = 1'b1;
      end else begin
         ms = 1'b1; m_n = m_n + 1;
      end
      lw = s.re0 && s.rde != 5'd0 && (s.rde == s.rs1d || s.rde == s.rs2d);
      if (ms)           begin e.stall = 4'b1111; e.flush = 3'b001; end
      else if (s.pcsrc) begin e.stall = 4'b0000; e.flush = 3'b110; end
      else if (lw)      begin e.stall = 4'b1100; e.flush = 3'b010; end
      else              begin e.stall = 4'b0000; e.flush = 3'b000; end
      if (s.perfclr)                        m_cnt = 0;
      else if (e.stall[3] && m_cnt < CMAX) m_cnt = m_cnt + 1;
   endtask

   task automatic step(input stim_t s);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n          = s.rst_n;
      hz.Rs1D        = s.rs1d;  hz.Rs2D = s.rs2d;
      hz.Rs1E        = s.rs1e;  hz.Rs2E = s.rs2e;
      hz.RdE         = s.rde;   hz.RdM  = s.rdm;  hz.RdW = s.rdw;
      hz.ResultSrcE0 = s.re0;   hz.RegWriteM = s.rwm; hz.RegWriteW = s.rww;
      hz.PCSrcE      = s.pcsrc; hz.MemReqM = s.memreq; hz.MemReadyM = s.memrdy;
      hz.PerfClr     = s.perfclr;
      model(s, e);
      q.push_back(e);
   endtask

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   // Monitor: every cycle the DUT presents a response; compare it with the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("stall_fdem", int'({hz.StallF, hz.StallD, hz.StallE, hz.StallM}), int'(e.stall));
            chk("flush_dew",  int'({hz.FlushD, hz.FlushE, hz.FlushW}), int'(e.flush));
            chk("fwd_a",      int'(hz.ForwardAE), int'(e.fa));
            chk("fwd_b",      int'(hz.ForwardBE), int'(e.fb));
            chk("mem_timeout", int'(hz.MemTimeout), int'(e.to));
            chk("stall_count", int'(hz.StallCount), e.cnt);
         end
      end
   end

   initial begin
      stim_t s;
      s = idle();
      s.rst_n = 1'b0;
      repeat (2) step(s);
      // load-use, then RdE=x0 variant
      s = idle(); s.re0 = 1'b1; s.rde = 5'd5; s.rs1d = 5'd5; step(s);
      s.rde = 5'd0; s.rs1d = 5'd0; step(s);
      // forwarding priority and x0
      s = idle(); s.rwm = 1'b1; s.rdm = 5'd3; s.rww = 1'b1; s.rdw = 5'd3;
      s.rs1e = 5'd3; s.rs2e = 5'd7; step(s);
      s.rdm = 5'd0; step(s);
      // branch beats load-use
      s = idle(); s.pcsrc = 1'b1; s.re0 = 1'b1; s.rde = 5'd5; s.rs1d = 5'd5; step(s);
      // memory wait of 3 cycles with a branch during the wait
      s = idle(); s.perfclr = 1'b1; step(s);
      s = idle(); s.memreq = 1'b1; step(s);
      s.pcsrc = 1'b1; step(s);
      s.pcsrc = 1'b0; step(s);
      s.memrdy = 1'b1; step(s);
      step(idle());
      // timeout, then sticky
      s = idle(); s.memreq = 1'b1;
      repeat (5) step(s);
      repeat (2) step(idle());
      // reset mid-wait
      s = idle(); s.memreq = 1'b1;
      repeat (2) step(s);
      s.rst_n = 1'b0; repeat (2) step(s);
      s.rst_n = 1'b1; s.memrdy = 1'b1; step(s);
      // saturation of the counter through repeated timeouts
      s = idle(); s.memreq = 1'b1;
      repeat (30) step(s);
      // random traffic
      for (int i = 0; i < 2000; i++) begin
         s.rst_n   = ($urandom_range(0, 299) != 0);
         s.rs1d    = 5'($urandom_range(0, 7));
         s.rs2d    = 5'($urandom_range(0, 7));
         s.rs1e    = 5'($urandom_range(0, 7));
         s.rs2e    = 5'($urandom_range(0, 7));
         s.rde     = 5'($urandom_range(0, 7));
         s.rdm     = 5'($urandom_range(0, 7));
         s.rdw     = 5'($urandom_range(0, 7));
         s.re0     = 1'($urandom_range(0, 1));
         s.rwm     = 1'($urandom_range(0, 1));
         s.rww     = 1'($urandom_range(0, 1));
         s.pcsrc   = ($urandom_range(0, 3) == 0);
         s.memreq  = ($urandom_range(0, 2) != 0);
         s.memrdy  = ($urandom_range(0, 2) == 0);
         s.perfclr = ($urandom_range(0, 49) == 0);
         step(s);
      end
      @(negedge clk);
      #1;
      chk("scoreboard_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
